text_buffer_ctrl: RTL and testbench
===================================

# text_buffer_ctrl

Parametrised text-mode front end of the GPU: accepts byte commands from the CPU-side interrupt path over a valid/ready handshake and maintains a COLS×ROWS glyph buffer with a wrapping cursor. Supports signed cursor moves, a multi-cycle hardware clear and a display-refresh request. Exposes a synchronous read port so the scan-out/rasteriser stage can fetch glyphs independently of command traffic.

## Interface
- COLS, 80, text columns; must be ≥ 32
- ROWS, 60, text rows; must be ≥ 32
- GLYPH_W, 8, glyph code width; must be ≥ 8
- CLEAR_GLYPH, 8'h20, value written by clear (zero-extended to GLYPH_W)
- AW, $clog2(COLS*ROWS), derived buffer address width (localparam)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command this cycle
- cmd_op  in  2  00 STORE, 01 MOVE, 10 DISPLAY, 11 CLEAR
- cmd_data  in  GLYPH_W  glyph (STORE) or move descriptor (MOVE); ignored otherwise
- scan_addr  in  AW  scan-out read address (row-major, y*COLS+x)
- scan_glyph  out  GLYPH_W  registered read data
- cursor_x  out  $clog2(COLS)  current column
- cursor_y  out  $clog2(ROWS)  current row
- busy  out  1  clear sweep in progress
- frame_req  out  1  one-cycle pulse requesting a display refresh

## Operation
- Command accepted on cycle where cmd_valid && cmd_ready; no other command effect.
- STORE: buf[y*COLS+x] <= cmd_data; x increments. At x == COLS-1: x <= 0, y increments. At x == COLS-1 and y == ROWS-1: cursor <= (0,0). Cursor never holds an out-of-range value.
- MOVE: cmd_data[7] = 1 selects x, 0 selects y; cmd_data[6:0] is a two's-complement delta (−64..+63). New value = (cur + delta) mod N, true mathematical modulo (N = COLS or ROWS). Sum computed signed, width ≥ $clog2(N)+2; up to two add/subtract-N corrections (parameter floor of 32 guarantees sufficiency). Other axis unchanged. Bits above [7] ignored.
- DISPLAY: frame_req high for exactly the cycle after acceptance. Buffer and cursor unchanged.
- CLEAR: FSM IDLE → CLEAR. In CLEAR, one write per cycle of CLEAR_GLYPH, address counter 0..COLS*ROWS-1; on final write, cursor <= (0,0), state → IDLE.
- FSM states: IDLE (cmd_ready = 1, busy = 0), CLEAR (cmd_ready = 0, busy = 1). No other states.
- Reset entry: FSM enters CLEAR with counter 0, so buffer is defined after every reset.
- Scan port: dual-ported, never stalled by commands or clear. Same-cycle write and read of one address returns old data. scan_addr ≥ COLS*ROWS returns 0.

## Timing
- Reset values (async assert): cmd_ready 0, busy 1, frame_req 0, cursor_x 0, cursor_y 0, scan_glyph 0, clear counter 0, state CLEAR.
- First cmd_ready high COLS*ROWS cycles after rst_n deassertion edge (4800 for defaults).
- STORE/MOVE/DISPLAY: single cycle; cursor outputs reflect result the cycle after acceptance; back-to-back acceptance allowed every cycle.
- CLEAR accepted at cycle t: cmd_ready low from t+1 through t+COLS*ROWS; high again at t+COLS*ROWS+1.
- scan_glyph valid one cycle after scan_addr sampled.
- Reset asserted mid-clear or mid-anything: sweep restarts from address 0 after release; partial contents irrelevant.
- cmd_valid may drop without acceptance; no state change.

## Structure
- Package text_gpu_pkg: cmd_op_e enum (STORE, MOVE, DISPLAY, CLEAR), state_e enum (IDLE, CLEAR), MOVE descriptor bit-field constants (axis bit 7, delta [6:0]).
- Sub-module glyph_ram: simple dual-port, one synchronous write port, one registered read port, parametrised depth/width, read-before-write, no reset on array.
- Top holds FSM, clear counter, cursor arithmetic, address mux (sweep counter vs. cursor address).

## Test plan
- Reset release, defaults → cmd_ready low 4800 cycles; all 4800 addresses read 8'h20; cursor (0,0).
- Cursor at (79,59), STORE 8'h41 → buf[4799]=8'h41, cursor (0,0); STORE at (79,3) → cursor (0,4).
- Cursor x=0, MOVE 8'hFF (x, −1) → x=79; y=10, MOVE 8'h3F (y, +63) → y=13; y=5, MOVE 8'h40 (y, −64) → y=1.
- DISPLAY accepted → frame_req high exactly one cycle, cursor/buffer unchanged; two back-to-back DISPLAYs → two consecutive pulses.
- STORE 8'h55 at address 100 while scan_addr=100 same cycle → scan_glyph returns old value, next read 8'h55; scan_addr=4800 → 0.
- CLEAR accepted, rst_n pulsed at sweep index 2000 → sweep restarts, full 4800-cycle busy after release, buffer fully 8'h20.

Source files
------------

// File: rtl/text_gpu_pkg.sv
// Shared types and constants for the text-mode buffer controller.
package text_gpu_pkg;

  typedef enum logic [1:0] {
    OP_STORE   = 2'b00,
    OP_MOVE    = 2'b01,
    OP_DISPLAY = 2'b10,
    OP_CLEAR   = 2'b11
  } cmd_op_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int MOVE_AXIS_BIT  = 7;
  localparam int MOVE_DELTA_MSB = 6;
  localparam int MOVE_DELTA_LSB = 0;

  // True modulo for v in [-2n, 2n): at most two corrections either way.
  function automatic int wrap_mod(input int v, input int n);
    int r;
    r = v;
    if (r < 0) r = r + n;
    if (r < 0) r = r + n;
    if (r >= n) r = r - n;
    if (r >= n) r = r - n;
    return r;
  endfunction

endpackage

// File: rtl/glyph_ram.sv
// Simple dual-port glyph store: synchronous write, registered read-before-write,
// out-of-range read addresses return zero.
module glyph_ram #(
  parameter int DEPTH = 4800,
  parameter int W     = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   rdata <= '0;
    else if (int'(raddr) < DEPTH) rdata <= mem[raddr];
    else                          rdata <= '0;
  end

endmodule

// File: rtl/text_buffer_ctrl.sv
// Text-mode front end: command handshake, wrapping cursor, hardware clear sweep
// and an independent scan-out read port.
module text_buffer_ctrl
  import text_gpu_pkg::*;
#(
  parameter int         COLS        = 80,
  parameter int         ROWS        = 60,
  parameter int         GLYPH_W     = 8,
  parameter logic [7:0] CLEAR_GLYPH = 8'h20,
  localparam int        AW          = $clog2(COLS*ROWS),
  localparam int        XW          = $clog2(COLS),
  localparam int        YW          = $clog2(ROWS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [GLYPH_W-1:0] cmd_data,
  input  logic [AW-1:0]      scan_addr,
  output logic [GLYPH_W-1:0] scan_glyph,
  output logic [XW-1:0]      cursor_x,
  output logic [YW-1:0]      cursor_y,
  output logic               busy,
  output logic               frame_req
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(COLS*ROWS-1);
  localparam logic [XW-1:0] LAST_X    = XW'(COLS-1);
  localparam logic [YW-1:0] LAST_Y    = YW'(ROWS-1);

  state_e              state, state_d;
  logic [AW-1:0]       clr_cnt, clr_cnt_d;
  logic [XW-1:0]       x_d;
  logic [YW-1:0]       y_d;
  logic                frame_d;
  logic                we;
  logic [AW-1:0]       waddr, cur_addr;
  logic [GLYPH_W-1:0]  wdata;
  int                  delta;
  cmd_op_e             op;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state == ST_CLEAR);
  assign op        = cmd_op_e'(cmd_op);
  assign delta     = int'($signed(cmd_data[MOVE_DELTA_MSB:MOVE_DELTA_LSB]));
  assign cur_addr  = AW'(int'(cursor_y) * COLS + int'(cursor_x));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_CLEAR;
      clr_cnt   <= '0;
      cursor_x  <= '0;
      cursor_y  <= '0;
      frame_req <= 1'b0;
    end else begin
      state     <= state_d;
      clr_cnt   <= clr_cnt_d;
      cursor_x  <= x_d;
      cursor_y  <= y_d;
      frame_req <= frame_d;
    end
  end

  always_comb begin
    state_d   = state;
    clr_cnt_d = clr_cnt;
    x_d       = cursor_x;
    y_d       = cursor_y;
    frame_d   = 1'b0;
    we        = 1'b0;
    waddr     = cur_addr;
    wdata     = cmd_data;
    case (state)
      ST_CLEAR: begin
        we    = 1'b1;
        waddr = clr_cnt;
        wdata = GLYPH_W'(CLEAR_GLYPH);
        if (clr_cnt == LAST_ADDR) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
          x_d       = '0;
          y_d       = '0;
        end else begin
          clr_cnt_d = clr_cnt + 1'b1;
        end
      end
      default: begin
        if (cmd_valid) begin
          case (op)
            OP_STORE: begin
              we = 1'b1;
              if (cursor_x == LAST_X) begin
                x_d = '0;
                y_d = (cursor_y == LAST_Y) ? '0 : cursor_y + 1'b1;
              end else begin
                x_d = cursor_x + 1'b1;
              end
            end
            OP_MOVE: begin
              if (cmd_data[MOVE_AXIS_BIT])
                x_d = XW'(wrap_mod(int'(cursor_x) + delta, COLS));
              else
                y_d = YW'(wrap_mod(int'(cursor_y) + delta, ROWS));
            end
            OP_DISPLAY: frame_d = 1'b1;
            default: begin
              state_d   = ST_CLEAR;
              clr_cnt_d = '0;
            end
          endcase
        end
      end
    endcase
  end

  glyph_ram #(
    .DEPTH (COLS*ROWS),
    .W     (GLYPH_W),
    .AW    (AW)
  ) u_glyph_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (scan_addr),
    .rdata (scan_glyph)
  );

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Self-checking bench for text_buffer_ctrl against a behavioural buffer/cursor model.
module tb_text_buffer_ctrl;

  localparam int COLS  = 80;
  localparam int ROWS  = 60;
  localparam int TOTAL = COLS * ROWS;
  localparam int AW    = $clog2(TOTAL);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [7:0]    cmd_data;
  logic [AW-1:0] scan_addr;
  logic [7:0]    scan_glyph;
  logic [6:0]    cursor_x;
  logic [5:0]    cursor_y;
  logic          busy;
  logic          frame_req;

  int errors = 0;
  int checks = 0;

  logic [7:0] mbuf [TOTAL];
  int mx, my;

  always #5 clk = ~clk;

  text_buffer_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .scan_addr  (scan_addr),
    .scan_glyph (scan_glyph),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .busy       (busy),
    .frame_req  (frame_req)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int limit, output int n);
    n = 0;
    while (!cmd_ready && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, cmd_ready, 0);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_frame"}, frame_req, 0);
    check({tag, "_cx"}, cursor_x, 0);
    check({tag, "_cy"}, cursor_y, 0);
    check({tag, "_scan"}, scan_glyph, 0);
  endtask

  task automatic model_fill_clear();
    for (int a = 0; a < TOTAL; a++) mbuf[a] = 8'h20;
    mx = 0;
    my = 0;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [7:0] data);
    int d;
    int exp_frame;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
    exp_frame = 0;
    case (op)
      2'd0: begin
        mbuf[my*COLS + mx] = data;
        mx++;
        if (mx == COLS) begin
          mx = 0;
          my = (my + 1) % ROWS;
        end
      end
      2'd1: begin
        d = int'(data[6:0]);
        if (d >= 64) d = d - 128;
        if (data[7]) mx = ((mx + d) % COLS + COLS) % COLS;
        else         my = ((my + d) % ROWS + ROWS) % ROWS;
      end
      2'd2: exp_frame = 1;
      default: ;
    endcase
    check("cmd_cursor_x", cursor_x, mx);
    check("cmd_cursor_y", cursor_y, my);
    check("cmd_frame_req", frame_req, exp_frame);
  endtask

  task automatic goto(input int tx, input int ty);
    int diff;
    logic [7:0] dd;
    for (int i = 0; i < 8 && mx != tx; i++) begin
      diff = tx - mx;
      if (diff > 63) diff = 63;
      if (diff < -64) diff = -64;
      dd = {1'b1, diff[6:0]};
      do_cmd(2'd1, dd);
    end
    for (int i = 0; i < 8 && my != ty; i++) begin
      diff = ty - my;
      if (diff > 63) diff = 63;
      if (diff < -64) diff = -64;
      dd = {1'b0, diff[6:0]};
      do_cmd(2'd1, dd);
    end
  endtask

  task automatic read_check(input string tag, input int a);
    scan_addr = AW'(a);
    step();
    check(tag, scan_glyph, mbuf[a]);
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < TOTAL; a++) read_check(tag, a);
  endtask

  initial begin
    int n;
    int a;
    logic [7:0] old_v;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_data  = 8'h00;
    scan_addr = '0;
    mx = 0;
    my = 0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    rst_n = 1'b1;
    wait_ready(TOTAL + 500, n);
    check("init_sweep_len", n, TOTAL);
    model_fill_clear();
    check("init_cx", cursor_x, 0);
    check("init_cy", cursor_y, 0);
    check("init_busy", busy, 0);
    read_all("init_buf");

    // Wrap corner cases
    goto(79, 59);
    do_cmd(2'd0, 8'h41);
    check("wrap_end_cx", cursor_x, 0);
    check("wrap_end_cy", cursor_y, 0);
    read_check("wrap_end_buf", TOTAL - 1);
    check("wrap_end_const", scan_glyph, 8'h41);
    goto(79, 3);
    do_cmd(2'd0, 8'h42);
    check("row_wrap_cx", cursor_x, 0);
    check("row_wrap_cy", cursor_y, 4);

    // Signed moves
    goto(0, 10);
    do_cmd(2'd1, 8'hFF);
    check("move_x_neg1", cursor_x, 79);
    do_cmd(2'd1, 8'h3F);
    check("move_y_pos63", cursor_y, 13);
    goto(79, 5);
    do_cmd(2'd1, 8'h40);
    check("move_y_neg64", cursor_y, 1);
    check("move_y_keep_x", cursor_x, 79);

    // Display pulses
    do_cmd(2'd2, 8'h00);
    do_cmd(2'd2, 8'h00);
    step();
    check("display_end", frame_req, 0);
    check("display_cx", cursor_x, mx);

    // Dropped valid: no effect
    cmd_op   = 2'd0;
    cmd_data = 8'h99;
    step();
    check("idle_cx", cursor_x, mx);
    check("idle_cy", cursor_y, my);

    // Randomized command stream
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        step();
        check("rand_idle_frame", frame_req, 0);
      end else begin
        do_cmd(2'($urandom_range(0, 2)), 8'($urandom_range(0, 255)));
      end
    end
    for (int i = 0; i < 300; i++) begin
      a = $urandom_range(0, TOTAL - 1);
      read_check("rand_read", a);
    end

    // Read-before-write on the same address
    goto(20, 1);
    do_cmd(2'd0, 8'hAA);
    goto(20, 1);
    old_v     = mbuf[100];
    scan_addr = AW'(100);
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_data  = 8'h55;
    step();
    cmd_valid = 1'b0;
    check("rbw_old", scan_glyph, old_v);
    mbuf[100] = 8'h55;
    mx = 21;
    step();
    check("rbw_new", scan_glyph, 8'h55);
    check("rbw_cx", cursor_x, mx);
    scan_addr = AW'(TOTAL);
    step();
    check("oob_read", scan_glyph, 0);

    // Full clear from a cursor off the origin
    goto(33, 22);
    do_cmd(2'd3, 8'h00);
    check("clear_busy", busy, 1);
    check("clear_ready", cmd_ready, 0);
    wait_ready(TOTAL + 500, n);
    check("clear_len", n, TOTAL);
    model_fill_clear();
    check("clear_cx", cursor_x, 0);
    check("clear_cy", cursor_y, 0);
    for (int i = 0; i < 200; i++) begin
      a = $urandom_range(0, TOTAL - 1);
      read_check("clear_read", a);
    end

    // Reset in the middle of a clear sweep
    for (int i = 0; i < 50; i++) do_cmd(2'd0, 8'($urandom_range(0, 255)));
    do_cmd(2'd3, 8'h00);
    repeat (2000) step();
    check("midclr_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    check_reset_values("midclr_rst");
    step();
    step();
    rst_n = 1'b1;
    wait_ready(TOTAL + 500, n);
    check("midclr_len", n, TOTAL);
    model_fill_clear();
    check("midclr_cx", cursor_x, 0);
    check("midclr_cy", cursor_y, 0);
    read_all("midclr_buf");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
